pipelined_cla_subtractor: RTL



---
 rtl/pipelined_cla_subtractor.sv | 108 ++++++++++
 1 files changed

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage carry-lookahead subtractor: computes i_min + ~i_sub + 1 with the low
// half resolved in stage 1 and the high half plus final borrow in stage 2.
module pipelined_cla_subtractor #(
    parameter int WIDTH = 32,
    parameter int LOW_W = WIDTH / 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    localparam int HIGH_W = WIDTH - LOW_W;

    logic [WIDTH-1:0]  w_b_inv;
    logic [LOW_W-1:0]  w_g_lo;
    logic [LOW_W-1:0]  w_p_lo;
    logic [LOW_W-1:0]  w_diff_lo;
    logic              w_carry_lo;
    logic [HIGH_W-1:0] w_g_hi;
    logic [HIGH_W-1:0] w_p_hi;
    logic [HIGH_W-1:0] w_diff_hi;
    logic              w_carry_hi;
    logic              w_load1;
    logic              w_adv1;

    logic              r_s1_valid;
    logic [LOW_W-1:0]  r_s1_diff_lo;
    logic              r_s1_carry;
    logic [HIGH_W-1:0] r_s1_a_hi;
    logic [HIGH_W-1:0] r_s1_b_hi;
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;

    assign w_b_inv = ~i_sub;
    assign w_g_lo  = i_min[LOW_W-1:0] & w_b_inv[LOW_W-1:0];
    assign w_p_lo  = i_min[LOW_W-1:0] ^ w_b_inv[LOW_W-1:0];

    // The +1 of two's complement enters as the carry into bit 0.
    always_comb begin : stage1_cla
        logic [LOW_W:0] c;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < LOW_W; i++) begin
            c[i+1] = w_g_lo[i] | (w_p_lo[i] & c[i]);
        end
        w_diff_lo  = w_p_lo ^ c[LOW_W-1:0];
        w_carry_lo = c[LOW_W];
    end

    assign w_g_hi = r_s1_a_hi & r_s1_b_hi;
    assign w_p_hi = r_s1_a_hi ^ r_s1_b_hi;

    always_comb begin : stage2_cla
        logic [HIGH_W:0] c;
        c    = '0;
        c[0] = r_s1_carry;
        for (int i = 0; i < HIGH_W; i++) begin
            c[i+1] = w_g_hi[i] | (w_p_hi[i] & c[i]);
        end
        w_diff_hi  = w_p_hi ^ c[HIGH_W-1:0];
        w_carry_hi = c[HIGH_W];
    end

    assign w_adv1  = r_s1_valid & (~r_s2_valid | i_ready);
    assign o_ready = ~r_s1_valid | ~r_s2_valid | i_ready;
    assign w_load1 = i_valid & o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
        end else begin
            if (o_ready) begin
                r_s1_valid <= i_valid;
            end
            if (w_adv1) begin
                r_s2_valid <= 1'b1;
                r_diff     <= {w_diff_hi, r_s1_diff_lo};
                r_borrow   <= ~w_carry_hi;
            end else if (i_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // NOTE: stage-1 data needs no reset; it is only consumed while r_s1_valid is set.
    always_ff @(posedge i_clk) begin
        if (w_load1) begin
            r_s1_diff_lo <= w_diff_lo;
            r_s1_carry   <= w_carry_lo;
            r_s1_a_hi    <= i_min[WIDTH-1:LOW_W];
            r_s1_b_hi    <= w_b_inv[WIDTH-1:LOW_W];
        end
    end

    assign o_valid  = r_s2_valid;
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;
endmodule
